norm_onehot: RTL
================

Name: norm_onehot

Overview:
- Iterative normalizer feeding get_pow.
- Accepts an arbitrary WIDTH-bit word over a valid/ready handshake and left-shifts it one bit per cycle until the MSB is set.
- Emits the one-hot value of the original most-significant set bit, which get_pow converts to a power, plus the normalized mantissa, shift count and zero flag.
- Sits directly upstream of get_pow in the log datapath.

Parameters:
- WIDTH, 8, data word width; must be ≥2. CNT_W = $clog2(WIDTH) is derived, not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  WIDTH  word to normalize.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_onehot  out  WIDTH  1 << (WIDTH-1-out_shift); all zeros when out_zero=1.
- out_mant  out  WIDTH  in_data << out_shift, so MSB is set unless out_zero.
- out_shift  out  CNT_W  count of leading zeros of in_data; 0 when out_zero.
- out_zero  out  1  in_data was 0.

Behaviour:
- Reset (async, immediate): state=IDLE; out_valid=0, out_onehot=0, out_mant=0, out_shift=0, out_zero=0; in_ready=0 while rst is high.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Accept = in_valid && in_ready.
- On accept: load reg=in_data, cnt=0.
  - in_data==0: go to DONE with zero=1.
  - in_data[WIDTH-1]==1: go to DONE with cnt=0.
  - Otherwise: go to SHIFT.
- SHIFT, each cycle: reg<=reg<<1, cnt<=cnt+1. If the shifted value has its MSB set (old reg[WIDTH-2]==1), go to DONE; otherwise stay in SHIFT.
- Latency: for k leading zeros, out_valid rises k+1 cycles after the accept edge (k=0 and zero input both give 1 cycle). The block is not pipelined; one word is in flight.
- DONE: out_valid=1. All outputs are held stable until out_ready=1.
  - On the out handshake: go to IDLE, unless a new word is accepted in the same cycle. In that case load the new word per the accept rules. The back-to-back accept is allowed only via in_ready in DONE.
- in_valid while busy (SHIFT, or DONE without out_ready): ignored. The producer must hold the word.
- cnt never exceeds WIDTH-1; no wrap is possible because the zero input bypasses SHIFT.
- Reset asserted mid-SHIFT or mid-DONE: the result is discarded and the block returns to IDLE with all outputs cleared.
- out_onehot is driven from cnt by the decoder; get_pow(out_onehot) must equal WIDTH-1-out_shift.

Optional Feature:
- Macro: NORM_NIBBLE_SKIP_EN.
- Defined (and WIDTH≥8): in SHIFT, if reg[WIDTH-1:WIDTH-4]==0, shift by 4 and add 4 to cnt. Otherwise shift by 1 as normal. Done is detected on the MSB of the shifted value.
  - Latency for k leading zeros: floor(k/4) + (k mod 4) + 1.
  - Example: 0x05 (k=5): SHIFT cycle 1 gives 0x50, cnt=4; cycle 2 gives 0xA0, cnt=5; out_valid at accept+3.
- Undefined: 1-bit shift only. Outputs are identical in both builds; only latency differs.

Decomposition:
- log_pkg holds:
  - the state enum {IDLE, SHIFT, DONE};
  - a CNT_W helper function ($clog2 wrapper);
  - a NIBBLE constant = 4.
- One sub-module is natural: onehot_dec (CNT_W count → WIDTH one-hot, with a zero-force input), combinational and instantiated once.

Test Plan:
- Reset release, drive in_data=0x40: out_valid at accept+2 (k=1), out_onehot=0x40, out_mant=0x80, out_shift=1; downstream get_pow gives 6.
- in_data=0x05, out_ready=1 (macro off): out_valid at accept+6, out_onehot=0x04, out_mant=0xA0, out_shift=5. Macro on: same values at accept+3.
- in_data=0x80 then 0x01 back-to-back, out_ready=1: first result (shift 0, onehot 0x80) at +1; second accepted in the DONE cycle; result shift 7, onehot 0x01, mant 0x80.
- in_data=0x00: out_valid at +1, out_zero=1, out_onehot=0, out_shift=0, out_mant=0.
- Backpressure: 0x10 with out_ready=0 for 5 cycles: outputs stable (onehot 0x10, shift 3), in_ready=0, an extra in_valid is ignored.
- Assert rst while in SHIFT on 0x01: out_valid=0 immediately; after release, in_ready=1 and the next word 0x20 yields shift 2.

Source files
------------

// File: rtl/log_pkg.sv
// rtl/log_pkg.sv - shared types and constants for the log datapath front end
package log_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int NIBBLE = 4;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/norm_onehot_dec.sv
// rtl/norm_onehot_dec.sv - shift count to one-hot MSB position decoder with zero force
module onehot_dec
    import log_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [cnt_w(WIDTH)-1:0] cnt,
    input  logic                    force_zero,
    output logic [WIDTH-1:0]        onehot
);

    localparam int CNT_W = cnt_w(WIDTH);

    // Bit WIDTH-1-cnt is the original most-significant set bit.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            onehot[i] = !force_zero && (cnt == CNT_W'(WIDTH - 1 - i));
        end
    end

endmodule

// File: rtl/norm_onehot.sv
// rtl/norm_onehot.sv - iterative left normalizer; NORM_NIBBLE_SKIP_EN enables 4-bit skip shifts
module norm_onehot
    import log_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_onehot,
    output logic [WIDTH-1:0]        out_mant,
    output logic [cnt_w(WIDTH)-1:0] out_shift,
    output logic                    out_zero
);

    localparam int CNT_W = cnt_w(WIDTH);

`ifdef NORM_NIBBLE_SKIP_EN
    localparam bit NIB_OK = (WIDTH >= 8);
    localparam int NIB_LO = NIB_OK ? WIDTH - NIBBLE : 0;
`endif

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mant_q, mant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               zero_q, zero_d;
    logic               done;
    logic               accept;

    assign done     = (state_q == DONE);
    assign in_ready = !rst && ((state_q == IDLE) || (done && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        mant_d  = mant_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        if (accept) begin
            mant_d  = in_data;
            cnt_d   = '0;
            zero_d  = (in_data == '0);
            // Zero and already-normalized words skip SHIFT, so cnt can never wrap.
            state_d = ((in_data == '0) || in_data[WIDTH-1]) ? DONE : SHIFT;
        end else begin
            case (state_q)
                SHIFT: begin
`ifdef NORM_NIBBLE_SKIP_EN
                    if (NIB_OK && (mant_q[WIDTH-1:NIB_LO] == '0)) begin
                        mant_d = mant_q << NIBBLE;
                        cnt_d  = cnt_q + CNT_W'(NIBBLE);
                    end else
`endif
                    begin
                        mant_d = mant_q << 1;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                    if (mant_d[WIDTH-1]) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mant_q  <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mant_q  <= mant_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
        end
    end

    assign out_valid = done;
    assign out_mant  = done ? mant_q : '0;
    assign out_shift = done ? cnt_q : '0;
    assign out_zero  = done && zero_q;

    onehot_dec #(
        .WIDTH(WIDTH)
    ) u_dec (
        .cnt       (cnt_q),
        .force_zero(!done || zero_q),
        .onehot    (out_onehot)
    );

endmodule
